// File: rtl/uart_transmitter.sv
// UART transmit engine: frames one character (start, 5-8 data bits LSB first,
// optional parity, 1/1.5/2 stop bits) on SOUT, timed by the 16x TXCLK enable.
module uart_transmitter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TXCLK,
  input  logic       TXSTART,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic [7:0] DIN,
  output logic       TXFINISHED,
  output logic       SOUT
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  baudCnt_q, baudCnt_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [4:0]  stopCnt_q, stopCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  wls_q, wls_d;
  logic        stb_q, stb_d;
  logic        pen_q, pen_d;
  logic        parBit_q, parBit_d;
  logic        sout_q, sout_d;

  logic        baudStep;
  logic        stopDone;
  logic [4:0]  stopLast;
  logic [7:0]  wordMask;

  assign baudStep   = TXCLK && (baudCnt_q == 4'd15);
  // 1.5 stop bits only exist for 5-bit words; otherwise STB selects 2 bits
  assign stopLast   = stb_q ? ((wls_q == 2'b00) ? 5'd23 : 5'd31) : 5'd15;
  assign stopDone   = (state_q == STOP) && TXCLK && (stopCnt_q == stopLast);
  assign TXFINISHED = stopDone;
  assign SOUT       = sout_q;

  always_comb begin
    case (WLS)
      2'b00:   wordMask = 8'h1F;
      2'b01:   wordMask = 8'h3F;
      2'b10:   wordMask = 8'h7F;
      default: wordMask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    stopCnt_d = stopCnt_q;
    shift_d   = shift_q;
    wls_d     = wls_q;
    stb_d     = stb_q;
    pen_d     = pen_q;
    parBit_d  = parBit_q;

    case (state_q)
      IDLE: begin
        baudCnt_d = 4'd0;
        if (TXSTART) begin
          state_d   = START;
          shift_d   = DIN;
          wls_d     = WLS;
          stb_d     = STB;
          pen_d     = PEN;
          bitCnt_d  = 3'd0;
          stopCnt_d = 5'd0;
          // Parity is fixed at frame start since the shift register is consumed
          parBit_d  = SP ? ~EPS : (^(DIN & wordMask)) ^ ~EPS;
        end
      end
      START: begin
        if (TXCLK) baudCnt_d = baudCnt_q + 4'd1;
        if (baudStep) state_d = DATA;
      end
      DATA: begin
        if (TXCLK) baudCnt_d = baudCnt_q + 4'd1;
        if (baudStep) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bitCnt_q == (3'd4 + {1'b0, wls_q})) begin
            bitCnt_d = 3'd0;
            state_d  = pen_q ? PAR : STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
      PAR: begin
        if (TXCLK) baudCnt_d = baudCnt_q + 4'd1;
        if (baudStep) state_d = STOP;
      end
      STOP: begin
        baudCnt_d = 4'd0;
        if (TXCLK) stopCnt_d = stopCnt_q + 5'd1;
        if (stopDone) begin
          stopCnt_d = 5'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sout_d = 1'b1;
    if (BC) begin
      sout_d = 1'b0;
    end else begin
      case (state_q)
        START:   sout_d = 1'b0;
        DATA:    sout_d = shift_q[0];
        PAR:     sout_d = parBit_q;
        default: sout_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      baudCnt_q <= 4'd0;
      bitCnt_q  <= 3'd0;
      stopCnt_q <= 5'd0;
      shift_q   <= 8'd0;
      wls_q     <= 2'd0;
      stb_q     <= 1'b0;
      pen_q     <= 1'b0;
      parBit_q  <= 1'b0;
      sout_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      stopCnt_q <= stopCnt_d;
      shift_q   <= shift_d;
      wls_q     <= wls_d;
      stb_q     <= stb_d;
      pen_q     <= pen_d;
      parBit_q  <= parBit_d;
      sout_q    <= sout_d;
    end
  end

endmodule
